// File: rtl/mem_port_arbiter_if.sv
`timescale 1ns/1ps
`default_nettype none
//------------------------------------------------------------------------------
// Module   : mem_port_arbiter_if
// Purpose  : Bundles the fetch port, the load/store port and the single-port
//            memory bus that mem_port_arbiter sits between.
// Ports    : i_req/i_addr -> i_gnt/i_valid          (instruction fetch)
//            d_req/d_we/d_addr/d_wdata -> d_gnt/d_valid (load/store)
//            rdata                                  (shared read return)
//            m_en/m_we/m_addr/m_wdata -> m_rdata    (memory side)
// Modports : slave  - the arbiter
//            master - the core/memory environment around it
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
interface mem_port_arbiter_if #(
   parameter int ADDR_W = 32
) ();
   logic              i_req;
   logic [ADDR_W-1:0] i_addr;
   logic              i_gnt;
   logic              i_valid;
   logic              d_req;
   logic              d_we;
   logic [ADDR_W-1:0] d_addr;
   logic [31:0]       d_wdata;
   logic              d_gnt;
   logic              d_valid;
   logic [31:0]       rdata;
   logic              m_en;
   logic              m_we;
   logic [ADDR_W-1:0] m_addr;
   logic [31:0]       m_wdata;
   logic [31:0]       m_rdata;

   modport slave (
      input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, m_rdata,
      output i_gnt, i_valid, d_gnt, d_valid, rdata, m_en, m_we, m_addr, m_wdata
   );

   modport master (
      output i_req, i_addr, d_req, d_we, d_addr, d_wdata, m_rdata,
      input  i_gnt, i_valid, d_gnt, d_valid, rdata, m_en, m_we, m_addr, m_wdata
   );
endinterface
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
//------------------------------------------------------------------------------
// Module   : mem_port_arbiter
// Purpose  : Shares one single-port synchronous memory between the core's
//            instruction-fetch port and its load/store port. At most one
//            access is granted per cycle; every read is tagged with its source
//            and the matching valid pulse fires RD_LATENCY cycles later.
// Ports    : clk   - clock, rising edge
//            reset - asynchronous, active-high
//            bus   - mem_port_arbiter_if.slave (fetch, load/store, memory)
// Params   : ADDR_W     - address width
//            RD_LATENCY - memory read latency, 1..4 (tag pipeline depth)
//            MAX_D_RUN  - data grants allowed while fetch waits (fair mode)
// Options  : MEM_ARB_FAIR_EN - when defined, fetch is forced through after
//            MAX_D_RUN consecutive data grants; otherwise data has strict
//            priority and fetch may starve.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module mem_port_arbiter #(
   parameter int ADDR_W     = 32,
   parameter int RD_LATENCY = 1,
   parameter int MAX_D_RUN  = 4
) (
   input  logic              clk,
   input  logic              reset,
   mem_port_arbiter_if.slave bus
);

   localparam logic c_SRC_I = 1'b1;
   localparam logic c_SRC_D = 1'b0;

   if (RD_LATENCY < 1 || RD_LATENCY > 4) begin : g_bad_latency
      $error("mem_port_arbiter: RD_LATENCY must be in 1..4");
   end
   if (MAX_D_RUN < 1) begin : g_bad_run
      $error("mem_port_arbiter: MAX_D_RUN must be at least 1");
   end

   logic              w_i_gnt;
   logic              w_d_gnt;
   logic              w_force;
   logic [ADDR_W-1:0] w_m_addr;
   logic              w_tag_vld_in;
   logic              w_tag_src_in;

`ifdef MEM_ARB_FAIR_EN
   localparam int               CNT_W     = $clog2(MAX_D_RUN + 1);
   localparam logic [CNT_W-1:0] c_RUN_MAX = CNT_W'(MAX_D_RUN);
   localparam logic [0:0]       c_D_PRI   = 1'b0;
   localparam logic [0:0]       c_I_FORCE = 1'b1;

   logic [0:0]       r_state;
   logic [0:0]       w_state_nxt;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_cnt_nxt;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= c_D_PRI;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   // The run counter only measures data grants that overtook a waiting fetch.
   // The switch to I_FORCE is taken on the edge that closes the MAX_D_RUN-th
   // such grant, so fetch is served in the very next cycle.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      case (r_state)
         c_D_PRI: begin
            if (!bus.i_req || w_i_gnt) begin
               w_cnt_nxt = '0;
            end else if (w_d_gnt) begin
               w_cnt_nxt = r_cnt + 1'b1;
               if (w_cnt_nxt == c_RUN_MAX) begin
                  w_state_nxt = c_I_FORCE;
               end
            end
         end
         c_I_FORCE: begin
            if (w_i_gnt || !bus.i_req) begin
               w_state_nxt = c_D_PRI;
               w_cnt_nxt   = '0;
            end
         end
         default: begin
            w_state_nxt = c_D_PRI;
            w_cnt_nxt   = '0;
         end
      endcase
   end

   assign w_force = (r_state == c_I_FORCE);
`else
   assign w_force = 1'b0;
`endif

   // Grants are gated by reset so that the combinational outputs drop the
   // moment reset rises, not at the next edge.
   always_comb begin
      w_i_gnt = 1'b0;
      w_d_gnt = 1'b0;
      if (!reset) begin
         if (w_force) begin
            w_i_gnt = bus.i_req;
            w_d_gnt = bus.d_req & ~bus.i_req;
         end else begin
            w_d_gnt = bus.d_req;
            w_i_gnt = bus.i_req & ~bus.d_req;
         end
      end
   end

   assign w_m_addr    = w_d_gnt ? bus.d_addr : (w_i_gnt ? bus.i_addr : '0);
   assign bus.i_gnt   = w_i_gnt;
   assign bus.d_gnt   = w_d_gnt;
   assign bus.m_en    = w_i_gnt | w_d_gnt;
   assign bus.m_we    = w_d_gnt & bus.d_we;
   assign bus.m_addr  = w_m_addr;
   assign bus.m_wdata = w_d_gnt ? bus.d_wdata : 32'h0;
   assign bus.rdata   = bus.m_rdata;

   // Stores complete at grant, so only reads enter the tag pipeline.
   assign w_tag_vld_in = w_i_gnt | (w_d_gnt & ~bus.d_we);
   assign w_tag_src_in = w_i_gnt ? c_SRC_I : c_SRC_D;

   logic [RD_LATENCY-1:0] r_tag_vld;
   logic [RD_LATENCY-1:0] r_tag_src;

   if (RD_LATENCY == 1) begin : g_tag_single
      always_ff @(posedge clk or posedge reset) begin
         if (reset) begin
            r_tag_vld <= '0;
            r_tag_src <= '0;
         end else begin
            r_tag_vld <= w_tag_vld_in;
            r_tag_src <= w_tag_src_in;
         end
      end
   end else begin : g_tag_shift
      always_ff @(posedge clk or posedge reset) begin
         if (reset) begin
            r_tag_vld <= '0;
            r_tag_src <= '0;
         end else begin
            r_tag_vld <= {r_tag_vld[RD_LATENCY-2:0], w_tag_vld_in};
            r_tag_src <= {r_tag_src[RD_LATENCY-2:0], w_tag_src_in};
         end
      end
   end

   assign bus.i_valid = r_tag_vld[RD_LATENCY-1] & (r_tag_src[RD_LATENCY-1] == c_SRC_I);
   assign bus.d_valid = r_tag_vld[RD_LATENCY-1] & (r_tag_src[RD_LATENCY-1] == c_SRC_D);

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
//------------------------------------------------------------------------------
// Module   : tb_mem_port_arbiter
// Purpose  : Self-checking bench. Three arbiters (RD_LATENCY 1, 2, 3) share
//            one stimulus stream; each has its own behavioural write-first
//            memory. Expected reads are queued at grant time and consumed
//            when their return cycle comes up.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module tb_mem_port_arbiter;

`ifdef MEM_ARB_FAIR_EN
   localparam bit FAIR = 1'b1;
`else
   localparam bit FAIR = 1'b0;
`endif
   localparam int NDUT = 3;

   typedef struct {
      logic        ir;
      logic [31:0] ia;
      logic        dr;
      logic        dw;
      logic [31:0] da;
      logic [31:0] dwd;
      logic        eig;
      logic        edg;
   } vec_t;

   typedef struct {
      int          cyc;
      logic        src_i;
      logic [31:0] data;
   } exp_t;

   logic        clk = 1'b0;
   logic        tb_reset;
   logic        mem_clr;
   logic        tb_i_req;
   logic [31:0] tb_i_addr;
   logic        tb_d_req;
   logic        tb_d_we;
   logic [31:0] tb_d_addr;
   logic [31:0] tb_d_wdata;

   logic [67:0] ob_gnt [NDUT];
   logic        ob_iv  [NDUT];
   logic        ob_dv  [NDUT];
   logic [31:0] ob_rd  [NDUT];

   logic [31:0] ref_mem [0:255];
   exp_t        expq [$];
   int          ptr [NDUT];
   int          nchk;
   int          nerr;
   int          cycle;
   vec_t        vt [20];

   always #5 clk = ~clk;

   function automatic logic [31:0] init_word(input logic [7:0] w);
      case (w)
         8'h04:   init_word = 32'hDEADBEEF;
         8'h40:   init_word = 32'h00000055;
         default: init_word = {16'hB00C, 8'h00, w};
      endcase
   endfunction

   for (genvar k = 0; k < NDUT; k++) begin : g_dut
      localparam int LAT = k + 1;

      mem_port_arbiter_if #(.ADDR_W(32)) bus ();

      logic [31:0]  mem [0:255];
      logic [255:0] wflag;
      logic [31:0]  rd_pipe [0:LAT-1];
      logic [7:0]   idx;

      assign bus.i_req   = tb_i_req;
      assign bus.i_addr  = tb_i_addr;
      assign bus.d_req   = tb_d_req;
      assign bus.d_we    = tb_d_we;
      assign bus.d_addr  = tb_d_addr;
      assign bus.d_wdata = tb_d_wdata;
      assign bus.m_rdata = rd_pipe[LAT-1];
      assign idx         = bus.m_addr[9:2];

      assign ob_gnt[k] = {bus.i_gnt, bus.d_gnt, bus.m_en, bus.m_we, bus.m_addr, bus.m_wdata};
      assign ob_iv[k]  = bus.i_valid;
      assign ob_dv[k]  = bus.d_valid;
      assign ob_rd[k]  = bus.rdata;

      mem_port_arbiter #(
         .ADDR_W     (32),
         .RD_LATENCY (LAT),
         .MAX_D_RUN  (4)
      ) u_dut (
         .clk   (clk),
         .reset (tb_reset),
         .bus   (bus)
      );

      // Write-first single-port memory with LAT cycles of read latency.
      always @(posedge clk) begin
         if (mem_clr) begin
            wflag <= '0;
         end else if (bus.m_en && bus.m_we) begin
            mem[idx]   <= bus.m_wdata;
            wflag[idx] <= 1'b1;
         end
         rd_pipe[0] <= (bus.m_en && !bus.m_we) ? (wflag[idx] ? mem[idx] : init_word(idx)) : 32'h0;
         for (int j = 1; j < LAT; j++) rd_pipe[j] <= rd_pipe[j-1];
      end
   end

   task automatic chk(input string nm, input int k, input logic [99:0] act, input logic [99:0] want);
      nchk++;
      if (act !== want) begin
         nerr++;
         $display("FAIL %s lat=%0d cycle=%0d got=%h want=%h", nm, k + 1, cycle, act, want);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      cycle++;
      #1;
   endtask

   // Called at posedge+1: drive one cycle, check mid-cycle, update the model.
   task automatic run_cycle(input vec_t v);
      logic [67:0] eg;
      logic [33:0] er;
      logic [33:0] ar;
      tb_i_req   = v.ir;
      tb_i_addr  = v.ia;
      tb_d_req   = v.dr;
      tb_d_we    = v.dw;
      tb_d_addr  = v.da;
      tb_d_wdata = v.dwd;
      #3;
      eg = {v.eig, v.edg, v.eig | v.edg, v.edg & v.dw,
            (v.edg ? v.da : (v.eig ? v.ia : 32'h0)),
            (v.edg ? v.dwd : 32'h0)};
      for (int k = 0; k < NDUT; k++) begin
         chk("grant", k, ob_gnt[k], eg);
         er = '0;
         if (ptr[k] < expq.size() && expq[ptr[k]].cyc + k + 1 == cycle) begin
            er = {expq[ptr[k]].src_i, ~expq[ptr[k]].src_i, expq[ptr[k]].data};
            ptr[k]++;
         end
         ar = {ob_iv[k], ob_dv[k], (ob_iv[k] | ob_dv[k]) ? ob_rd[k] : 32'h0};
         chk("response", k, ar, er);
      end
      if (v.eig) expq.push_back('{cycle, 1'b1, ref_mem[v.ia[9:2]]});
      if (v.edg && !v.dw) expq.push_back('{cycle, 1'b0, ref_mem[v.da[9:2]]});
      if (v.edg && v.dw) ref_mem[v.da[9:2]] = v.dwd;
      tick();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog cycle=%0d", cycle);
      $fatal(1, "watchdog expired");
   end

   initial begin
      vec_t v;
      int   dcnt;
      nchk  = 0;
      nerr  = 0;
      cycle = 0;
      for (int i = 0; i < NDUT; i++) ptr[i] = 0;
      for (int i = 0; i < 256; i++) ref_mem[i] = init_word(8'(i));

      //     ir    ia          dr    dw    da          dwd           eig   edg
      vt[0]  = '{1'b0, 32'h0,   1'b0, 1'b0, 32'h0,   32'h0,        1'b0, 1'b0};
      vt[1]  = '{1'b1, 32'h10,  1'b0, 1'b0, 32'h0,   32'h0,        1'b1, 1'b0};
      vt[2]  = '{1'b1, 32'h20,  1'b1, 1'b0, 32'h100, 32'h0,        1'b0, 1'b1};
      vt[3]  = '{1'b1, 32'h20,  1'b0, 1'b0, 32'h0,   32'h0,        1'b1, 1'b0};
      vt[4]  = '{1'b0, 32'h0,   1'b1, 1'b1, 32'h40,  32'hCAFE0001, 1'b0, 1'b1};
      vt[5]  = '{1'b0, 32'h0,   1'b1, 1'b0, 32'h40,  32'h0,        1'b0, 1'b1};
      vt[6]  = '{1'b0, 32'h0,   1'b0, 1'b0, 32'h0,   32'h0,        1'b0, 1'b0};
      vt[7]  = '{1'b1, 32'h200, 1'b0, 1'b0, 32'h0,   32'h0,        1'b1, 1'b0};
      vt[8]  = '{1'b0, 32'h0,   1'b1, 1'b0, 32'h304, 32'h0,        1'b0, 1'b1};
      vt[9]  = '{1'b1, 32'h208, 1'b0, 1'b0, 32'h0,   32'h0,        1'b1, 1'b0};
      vt[10] = '{1'b0, 32'h0,   1'b1, 1'b0, 32'h30C, 32'h0,        1'b0, 1'b1};
      vt[11] = '{1'b1, 32'h210, 1'b0, 1'b0, 32'h0,   32'h0,        1'b1, 1'b0};
      vt[12] = '{1'b0, 32'h0,   1'b1, 1'b0, 32'h314, 32'h0,        1'b0, 1'b1};
      vt[13] = '{1'b1, 32'h218, 1'b0, 1'b0, 32'h0,   32'h0,        1'b1, 1'b0};
      vt[14] = '{1'b0, 32'h0,   1'b1, 1'b0, 32'h31C, 32'h0,        1'b0, 1'b1};
      vt[15] = '{1'b1, 32'h80,  1'b1, 1'b1, 32'h80,  32'h12345678, 1'b0, 1'b1};
      vt[16] = '{1'b1, 32'h80,  1'b1, 1'b0, 32'h80,  32'h0,        1'b0, 1'b1};
      vt[17] = '{1'b1, 32'h80,  1'b0, 1'b0, 32'h0,   32'h0,        1'b1, 1'b0};
      vt[18] = '{1'b0, 32'h0,   1'b1, 1'b1, 32'h84,  32'hA5A50F0F, 1'b0, 1'b1};
      vt[19] = '{1'b0, 32'h0,   1'b0, 1'b0, 32'h0,   32'h0,        1'b0, 1'b0};

      // Reset state: requests high, yet nothing may be granted or driven.
      tb_reset   = 1'b1;
      mem_clr    = 1'b1;
      tb_i_req   = 1'b1;
      tb_i_addr  = 32'h10;
      tb_d_req   = 1'b1;
      tb_d_we    = 1'b1;
      tb_d_addr  = 32'h40;
      tb_d_wdata = 32'h11112222;
      repeat (2) @(posedge clk);
      #1;
      for (int k = 0; k < NDUT; k++) begin
         chk("reset_grant", k, ob_gnt[k], 68'h0);
         chk("reset_valid", k, {ob_iv[k], ob_dv[k]}, 2'b00);
      end
      tb_reset = 1'b0;
      mem_clr  = 1'b0;

      for (int i = 0; i < 20; i++) run_cycle(vt[i]);

      // Both requests held: data wins; with the fair option fetch gets every
      // fifth slot.
      dcnt = 0;
      for (int s = 0; s < 10; s++) begin
         v.ir  = 1'b1;
         v.ia  = 32'h20;
         v.dr  = 1'b1;
         v.dw  = 1'b0;
         v.da  = 32'h100 + 32'(4 * dcnt);
         v.dwd = 32'h0;
         v.eig = FAIR && (s % 5 == 4);
         v.edg = !v.eig;
         if (v.edg) dcnt++;
         run_cycle(v);
      end
      run_cycle(vt[0]);
      run_cycle(vt[0]);

      // Reset one cycle after a load grant: in-flight tags must vanish.
      v = '{1'b0, 32'h0, 1'b1, 1'b0, 32'h100, 32'h0, 1'b0, 1'b1};
      run_cycle(v);
      tb_i_req  = 1'b1;
      tb_i_addr = 32'h20;
      tb_d_req  = 1'b1;
      tb_d_we   = 1'b0;
      tb_d_addr = 32'h40;
      #1;
      tb_reset = 1'b1;
      #1;
      for (int k = 0; k < NDUT; k++) begin
         chk("midreset_grant", k, ob_gnt[k], 68'h0);
         chk("midreset_valid", k, {ob_iv[k], ob_dv[k]}, 2'b00);
         ptr[k] = expq.size();
      end
      tick();
      tick();
      tb_reset = 1'b0;
      tb_i_req = 1'b0;
      tb_d_req = 1'b0;
      for (int i = 0; i < 5; i++) run_cycle(vt[0]);
      run_cycle(vt[1]);
      for (int i = 0; i < 4; i++) run_cycle(vt[0]);

      for (int k = 0; k < NDUT; k++) begin
         chk("drained", k, 100'(expq.size() - ptr[k]), 100'h0);
      end

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port synchronous memory between the core's instruction-fetch port and its load/store port.
- Sits between the pipelined core and the unified BRAM.
- Grants at most one access per cycle, tags each in-flight access with its source, and returns read data with a per-source valid pulse after a fixed read latency.
- Fetch stalls are generated from a deasserted i_gnt.

Parameters:
- ADDR_W, 32, address width of all address ports.
- RD_LATENCY, 1, memory read latency in cycles (legal 1..4); depth of the tag pipeline.
- MAX_D_RUN, 4, consecutive data grants allowed while fetch is waiting (used only with the optional feature).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- i_req  input  1  fetch request; held with i_addr until i_gnt.
- i_addr  input  ADDR_W  fetch byte address.
- i_gnt  output  1  fetch request accepted this cycle (combinational).
- i_valid  output  1  fetch read data valid on rdata this cycle.
- d_req  input  1  data request; held with d_we/d_addr/d_wdata until d_gnt.
- d_we  input  1  1 = store, 0 = load.
- d_addr  input  ADDR_W  data byte address.
- d_wdata  input  32  store data.
- d_gnt  output  1  data request accepted this cycle (combinational).
- d_valid  output  1  load data valid on rdata this cycle; never pulses for stores.
- rdata  output  32  shared read-data return bus; direct pass-through of m_rdata.
- m_en  output  1  memory access enable.
- m_we  output  1  memory write enable.
- m_addr  output  ADDR_W  memory byte address.
- m_wdata  output  32  memory write data.
- m_rdata  input  32  memory read data, valid RD_LATENCY cycles after an m_en read.

Behaviour:
- Reset, asynchronous and held while high:
  - Tag pipeline is cleared.
  - Run counter = 0 and FSM = D_PRI.
  - i_gnt, d_gnt, m_en, m_we, i_valid and d_valid are all 0.
  - m_addr and m_wdata are 0.
- Grant, combinational each cycle:
  - Only one of d_gnt and i_gnt may be 1.
  - m_en = d_gnt | i_gnt.
  - m_we = d_gnt & d_we.
  - m_addr and m_wdata come from the granted port; both are 0 when idle.
- Default arbitration (FSM state D_PRI):
  - Data has strict priority.
  - d_gnt = d_req.
  - i_gnt = i_req & ~d_req.
- Throughput:
  - One grant per cycle.
  - Back-to-back grants to either port are allowed.
  - No idle cycle is inserted between a store and a load.
- Tag pipeline:
  - RD_LATENCY stages of {valid, src}.
  - Stage 0 loads {i_gnt | (d_gnt & ~d_we), i_gnt ? I : D}.
  - The last stage drives the outputs: i_valid = valid & src==I; d_valid = valid & src==D.
  - Responses return in grant order.
  - Latency from grant to valid is exactly RD_LATENCY cycles.
- Store completion: a store completes at grant; no response is produced.
- Hazard ordering: a load granted in the cycle after a store to the same address returns the new data; memory write-first timing is required of the RAM.
- Requester rule: requester signals must stay stable while req=1 and gnt=0. The arbiter does not latch request contents.
- Reset mid-operation: in-flight tags are discarded; no valid pulse is produced for accesses granted before reset.
- Both req low: no grant, and the tag pipeline shifts in invalid.

Optional Feature:
- Macro: MEM_ARB_FAIR_EN.
- Defined:
  - The FSM has states D_PRI and I_FORCE.
  - In D_PRI, the run counter increments on each d_gnt issued while i_req=1.
  - The counter resets to 0 on any i_gnt, or on any cycle with i_req=0.
  - When the counter reaches MAX_D_RUN, the FSM moves to I_FORCE on the next edge.
  - In I_FORCE:
    - i_gnt = i_req and d_gnt = d_req & ~i_req.
    - The FSM returns to D_PRI after one i_gnt, or immediately if i_req=0; the counter clears.
  - Fetch therefore waits at most MAX_D_RUN cycles.
- Undefined: strict data priority; no counter or FSM logic is synthesized, and fetch can starve indefinitely.

Test Plan:
- Fetch-only read, RD_LATENCY=1:
  - Stimulus: i_req=1, i_addr=0x10; memory word at 0x10 = 0xDEADBEEF.
  - Response: i_gnt=1 in cycle 0; m_en=1 and m_addr=0x10 in cycle 0.
  - Response: i_valid=1 and rdata=0xDEADBEEF in cycle 1; d_valid stays 0.
- Simultaneous requests:
  - Stimulus: i_req=1 (0x20) and d_req=1 load (0x100, holding 0x55) in the same cycle.
  - Response: d_gnt=1 and i_gnt=0 in cycle 0; i_gnt=1 in cycle 1.
  - Response: d_valid with rdata=0x55 in cycle 1; i_valid in cycle 2.
- Store then load:
  - Stimulus: store 0xCAFE0001 to 0x40, then a load from 0x40 in the next cycle.
  - Response: m_we=1 only in the store cycle; no d_valid for the store.
  - Response: d_valid with rdata=0xCAFE0001 one cycle after the load grant.
- Starvation, MEM_ARB_FAIR_EN, MAX_D_RUN=4:
  - Stimulus: d_req held high and i_req held high.
  - Response: 4 d_gnt cycles, then i_gnt in the 5th cycle, then data resumes.
  - Without the macro: i_gnt never asserts.
- Latency, RD_LATENCY=3:
  - Stimulus: alternating I/D loads every cycle for 8 cycles.
  - Response: each valid appears exactly 3 cycles after its grant, with its source preserved and in order.
- Reset mid-flight, RD_LATENCY=2:
  - Stimulus: reset asserted 1 cycle after a load grant.
  - Response: i_valid, d_valid, i_gnt, d_gnt and m_en go to 0 immediately; no valid pulse appears after reset release.
